// File: rtl/screen_renderer.sv
// rtl/screen_renderer.sv - per-frame redraw: full-screen background fill, then up to six 8x8 sprites.
// Sprite pixels come from an external ROM with one cycle of read latency.
module screen_renderer #(
   parameter int          SCR_W       = 320,
   parameter int          SCR_H       = 240,
   parameter logic [4:0]  BLANK_CODE  = 5'd12,
   parameter logic [11:0] TRANSPARENT = 12'h000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        frame_tick,
   input  logic [1:0]  Screen,
   input  logic [11:0] background,
   input  logic [4:0]  ob1a,
   input  logic [4:0]  ob1b,
   input  logic [4:0]  ob2a,
   input  logic [4:0]  ob2b,
   input  logic [4:0]  ob3a,
   input  logic [4:0]  ob3b,
   input  logic [16:0] ob1axy,
   input  logic [16:0] ob1bxy,
   input  logic [16:0] ob2axy,
   input  logic [16:0] ob2bxy,
   input  logic [16:0] ob3axy,
   input  logic [16:0] ob3bxy,
   output logic [10:0] rom_addr,
   input  logic [11:0] rom_data,
   output logic [8:0]  x,
   output logic [7:0]  y,
   output logic [11:0] colour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, CLEAR, SPRITE, DRAIN, FINISH} state_t;

   state_t      state, state_nxt;
   logic        game_q;
   logic [11:0] bg_q;
   logic [4:0]  code_q [6];
   logic [16:0] xy_q [6];
   logic [8:0]  cx;
   logic [7:0]  cy;
   logic [2:0]  slot;
   logic [5:0]  pix;
   logic        spr_v;
   logic [9:0]  sx;
   logic [8:0]  sy;

   logic [4:0]  cur_code;
   logic        cur_blank;
   logic        last_px;
   logic        slot_end;

   assign cur_code  = code_q[slot];
   assign cur_blank = (cur_code == BLANK_CODE);
   assign last_px   = (cx == 9'(SCR_W - 1)) && (cy == 8'(SCR_H - 1));
   assign slot_end  = cur_blank || (pix == 6'd63);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         game_q <= 1'b0;
         bg_q   <= '0;
         cx     <= '0;
         cy     <= '0;
         slot   <= '0;
         pix    <= '0;
         spr_v  <= 1'b0;
         sx     <= '0;
         sy     <= '0;
         for (int i = 0; i < 6; i++) begin
            code_q[i] <= '0;
            xy_q[i]   <= '0;
         end
      end else begin
         state <= state_nxt;
         // Stage the coordinate of the pixel whose ROM read is in flight.
         spr_v <= (state == SPRITE) && !cur_blank;
         sx    <= {1'b0, xy_q[slot][16:8]} + {7'd0, pix[2:0]};
         sy    <= {1'b0, xy_q[slot][7:0]} + {6'd0, pix[5:3]};
         case (state)
            IDLE: if (frame_tick) begin
               game_q    <= (Screen == 2'b10);
               bg_q      <= background;
               code_q[0] <= ob1a;   xy_q[0] <= ob1axy;
               code_q[1] <= ob1b;   xy_q[1] <= ob1bxy;
               code_q[2] <= ob2a;   xy_q[2] <= ob2axy;
               code_q[3] <= ob2b;   xy_q[3] <= ob2bxy;
               code_q[4] <= ob3a;   xy_q[4] <= ob3axy;
               code_q[5] <= ob3b;   xy_q[5] <= ob3bxy;
               cx        <= '0;
               cy        <= '0;
               slot      <= '0;
               pix       <= '0;
            end
            CLEAR: begin
               if (cx == 9'(SCR_W - 1)) begin
                  cx <= '0;
                  cy <= cy + 8'd1;
               end else begin
                  cx <= cx + 9'd1;
               end
            end
            SPRITE: begin
               if (slot_end) begin
                  slot <= slot + 3'd1;
                  pix  <= '0;
               end else begin
                  pix <= pix + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      rom_addr  = '0;
      x         = '0;
      y         = '0;
      colour    = '0;
      plot      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (frame_tick) state_nxt = CLEAR;
         CLEAR: begin
            busy   = 1'b1;
            plot   = 1'b1;
            x      = cx;
            y      = cy;
            colour = bg_q;
            if (last_px) state_nxt = game_q ? SPRITE : FINISH;
         end
         SPRITE: begin
            busy = 1'b1;
            if (!cur_blank) rom_addr = {cur_code, pix};
            if (slot_end && slot == 3'd5) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (spr_v) begin
         x      = sx[8:0];
         y      = sy[7:0];
         colour = rom_data;
         plot   = (rom_data != TRANSPARENT) && (sx < 10'(SCR_W)) && (sy < 9'(SCR_H));
      end
   end

endmodule

// File: tb/tb_screen_renderer.sv
// tb/tb_screen_renderer.sv - randomized and directed frames checked against a plot-list reference model.
module tb_screen_renderer;
   localparam int W = 16;
   localparam int H = 8;
   localparam int AT_FINISH = -1;

   typedef struct {int cyc; int px; int py; int col;} plot_t;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic        frame_tick;
   logic [1:0]  Screen;
   logic [11:0] background;
   logic [4:0]  codes [6];
   logic [16:0] xys [6];
   logic [10:0] rom_addr;
   logic [11:0] rom_data = 12'h000;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [11:0] colour;
   logic        plot, busy, done;

   logic [11:0] rom_mem [0:2047];
   plot_t       exp_q[$];
   plot_t       obs_q[$];
   int          npass = 0;
   int          ntotal = 0;
   int          n_spr, n_even;

   screen_renderer #(.SCR_W(W), .SCR_H(H)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .frame_tick(frame_tick), .Screen(Screen),
      .background(background),
      .ob1a(codes[0]), .ob1b(codes[1]), .ob2a(codes[2]), .ob2b(codes[3]), .ob3a(codes[4]), .ob3b(codes[5]),
      .ob1axy(xys[0]), .ob1bxy(xys[1]), .ob2axy(xys[2]), .ob2bxy(xys[3]), .ob3axy(xys[4]), .ob3bxy(xys[5]),
      .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic set_xy(input int s, input int px, input int py);
      xys[s] = {9'(px), 8'(py)};
   endtask

   task automatic randomize_inputs();
      Screen     = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b10;
      background = 12'($urandom);
      for (int s = 0; s < 6; s++) begin
         codes[s] = ($urandom_range(2) == 0) ? 5'd12 : 5'($urandom);
         set_xy(s, $urandom_range(19), $urandom_range(11));
      end
   endtask

   task automatic randomize_rom();
      for (int a = 0; a < 2048; a++)
         rom_mem[a] = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom_range(4095, 1));
   endtask

   // Expected plots: raster fill, then each non-blank slot's visible, opaque pixels in order.
   task automatic build_model(output int len);
      int off;
      off = 0;
      exp_q.delete();
      for (int py = 0; py < H; py++)
         for (int px = 0; px < W; px++)
            exp_q.push_back('{py * W + px + 1, px, py, int'(background)});
      if (Screen == 2'b10) begin
         for (int s = 0; s < 6; s++) begin
            if (codes[s] == 5'd12) begin
               off += 1;
            end else begin
               for (int k = 0; k < 64; k++) begin
                  int px, py, col;
                  px  = int'(xys[s][16:8]) + k % 8;
                  py  = int'(xys[s][7:0]) + k / 8;
                  col = int'(rom_mem[int'(codes[s]) * 64 + k]);
                  if (col != 0 && px < W && py < H)
                     exp_q.push_back('{W * H + 2 + off + k, px, py, col});
               end
               off += 64;
            end
         end
         len = W * H + off + 2;
      end else begin
         len = W * H + 1;
      end
   endtask

   task automatic run_frame(input string tag, input int tick2_at, input bit change_mid,
                            output int spr, output int even);
      int len, done_cyc, done_cnt, busy_err, mism;
      build_model(len);
      obs_q.delete();
      done_cyc = -1; done_cnt = 0; busy_err = 0; mism = 0; spr = 0; even = 0;
      frame_tick = 1'b1;
      for (int n = 1; n <= len + 6; n++) begin
         @(negedge CLOCK_50);
         frame_tick = 1'b0;
         if (plot) begin
            obs_q.push_back('{n, int'(x), int'(y), int'(colour)});
            if (n > W * H) begin
               spr++;
               if (!x[0]) even++;
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (busy !== (n < len)) busy_err++;
         if (n == tick2_at || (tick2_at == AT_FINISH && n == len)) frame_tick = 1'b1;
         if (change_mid && n == 40) begin
            randomize_inputs();
            Screen = 2'b00;
         end
      end
      frame_tick = 1'b0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (exp_q[i] != obs_q[i]) mism++;
      check({tag, "_done_cycle"}, done_cyc, len);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_plot_count"}, obs_q.size(), exp_q.size());
      check({tag, "_plot_mismatch"}, mism, 0);
      check({tag, "_busy_errors"}, busy_err, 0);
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, {plot, busy, done}, 3'b000);
      check({tag, "_xy"}, {x, y}, 17'd0);
      check({tag, "_colour"}, colour, 12'h000);
      check({tag, "_rom_addr"}, rom_addr, 11'd0);
   endtask

   initial begin
      int seen_done, seen_plot;
      resetn = 1'b0;
      frame_tick = 1'b0;
      randomize_inputs();
      randomize_rom();
      repeat (3) @(negedge CLOCK_50);
      check_outputs_zero("reset");
      resetn = 1'b1;
      @(negedge CLOCK_50);

      // Non-game screen: background fill only.
      Screen = 2'b00; background = 12'h077;
      run_frame("nongame", 0, 0, n_spr, n_even);

      // Game screen, every slot blank.
      Screen = 2'b10;
      for (int s = 0; s < 6; s++) codes[s] = 5'd12;
      run_frame("all_blank", 0, 0, n_spr, n_even);

      // One solid sprite clipped at the bottom edge.
      for (int a = 0; a < 2048; a++) rom_mem[a] = 12'hF00;
      codes[0] = 5'd3; set_xy(0, 4, 2);
      run_frame("clip", 0, 0, n_spr, n_even);
      check("clip_sprite_plots", n_spr, 48);

      // Transparent even columns.
      for (int a = 0; a < 2048; a++) rom_mem[a] = a[0] ? 12'h0F0 : 12'h000;
      set_xy(0, 0, 0);
      run_frame("transp", 0, 0, n_spr, n_even);
      check("transp_sprite_plots", n_spr, 32);
      check("transp_even_x", n_even, 0);

      // Extra tick during CLEAR plus inputs changed mid-frame, then a tick in the FINISH cycle.
      randomize_rom();
      randomize_inputs();
      Screen = 2'b10;
      run_frame("tick_mid", 30, 1, n_spr, n_even);
      randomize_inputs();
      run_frame("tick_finish", AT_FINISH, 0, n_spr, n_even);

      // Reset asserted mid-frame.
      frame_tick = 1'b1;
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
      repeat (49) @(negedge CLOCK_50);
      #2 resetn = 1'b0;
      #1 check_outputs_zero("abort");
      seen_done = 0; seen_plot = 0;
      @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (700) begin
         @(negedge CLOCK_50);
         if (done) seen_done++;
         if (plot) seen_plot++;
      end
      check("abort_no_done", seen_done, 0);
      check("abort_no_plot", seen_plot, 0);
      randomize_inputs();
      run_frame("restart", 0, 0, n_spr, n_even);

      // Randomized frames.
      for (int f = 0; f < 5; f++) begin
         randomize_rom();
         randomize_inputs();
         run_frame($sformatf("rand%0d", f), 0, 0, n_spr, n_even);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
